// File: rtl/hs_pkg.sv
// Shared types and the round-robin pick helper for the handshake arbiter.
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    HOLD = 2'd2,
    RTZ  = 2'd3
  } hs_state_e;

  localparam int HS_MAX_N = 16;
  localparam int HS_IDX_W = 4;

  typedef logic [HS_IDX_W:0] hs_scan_t;

  typedef struct packed {
    logic                vld;
    logic [HS_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit at or after ptr, wrapping within n requesters.
  function automatic rr_pick_t rr_pick(input logic [HS_MAX_N-1:0] req,
                                       input logic [HS_IDX_W-1:0] ptr,
                                       input int                  n);
    rr_pick_t res;
    hs_scan_t j;
    res = '0;
    for (int k = 0; k < HS_MAX_N; k++) begin
      j = {1'b0, ptr} + hs_scan_t'(k);
      if (j >= hs_scan_t'(n)) j = j - hs_scan_t'(n);
      if ((k < n) && !res.vld && req[j[HS_IDX_W-1:0]]) begin
        res.vld = 1'b1;
        res.idx = j[HS_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hs_rr_arbiter_if.sv
// Bundle of the upstream/downstream handshake and status signals of the arbiter.
interface hs_rr_arbiter_if #(
  parameter int N     = 4,
  parameter int CNT_W = 16,
  parameter int IW    = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]     req_in_i;
  logic [N-1:0]     ack_in_o;
  logic             req_out_o;
  logic             ack_out_i;
  logic [N-1:0]     grant_o;
  logic [IW-1:0]    grant_idx_o;
  logic             busy_o;
  logic [CNT_W-1:0] txn_count_o;

  modport master (
    input  req_in_i, ack_out_i,
    output ack_in_o, req_out_o, grant_o, grant_idx_o, busy_o, txn_count_o
  );

  modport slave (
    output req_in_i, ack_out_i,
    input  ack_in_o, req_out_o, grant_o, grant_idx_o, busy_o, txn_count_o
  );
endinterface

// File: rtl/sync_ff.sv
// Width-parameterised flop chain for bringing handshake inputs into the clock domain.
module sync_ff #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (STAGES == 0) begin : g_wire
      logic w_unused;
      assign w_unused = clk_i ^ rst_i;
      assign q_o      = d_i;
    end else begin : g_flops
      logic [STAGES-1:0][W-1:0] r_chain;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_chain <= '0;
        end else begin
          r_chain[0] <= d_i;
          for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
        end
      end
      assign q_o = r_chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter serialising N four-phase requesters onto one four-phase channel.
module hs_rr_arbiter
  import hs_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  hs_rr_arbiter_if.master bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] w_req_s;
  logic [0:0]   w_ack_s;

  sync_ff #(.W(N), .STAGES(SYNC_STAGES)) u_sync_req (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (bus.req_in_i),
    .q_o   (w_req_s)
  );

  sync_ff #(.W(1), .STAGES(SYNC_STAGES)) u_sync_ack (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (bus.ack_out_i),
    .q_o   (w_ack_s)
  );

  hs_state_e        r_state, w_state_n;
  logic [IW-1:0]    r_ptr, w_ptr_n;
  logic [IW-1:0]    r_gidx, w_gidx_n;
  logic [N-1:0]     r_grant, w_grant_n;
  logic [N-1:0]     r_ack_in, w_ack_in_n;
  logic             r_req_out, w_req_out_n;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  rr_pick_t         w_pick;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_ack_in  <= '0;
      r_req_out <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_ptr     <= w_ptr_n;
      r_gidx    <= w_gidx_n;
      r_grant   <= w_grant_n;
      r_ack_in  <= w_ack_in_n;
      r_req_out <= w_req_out_n;
      r_busy    <= (w_state_n != IDLE);
      r_cnt     <= w_cnt_n;
    end
  end

  // Grant is latched in IDLE and held untouched until the token returns to zero.
  always_comb begin
    w_state_n   = r_state;
    w_ptr_n     = r_ptr;
    w_gidx_n    = r_gidx;
    w_grant_n   = r_grant;
    w_ack_in_n  = r_ack_in;
    w_req_out_n = r_req_out;
    w_cnt_n     = r_cnt;
    w_pick      = rr_pick(HS_MAX_N'(w_req_s), HS_IDX_W'(r_ptr), N);
    case (r_state)
      IDLE: begin
        if (w_pick.vld) begin
          w_gidx_n    = IW'(w_pick.idx);
          w_grant_n   = {{(N-1){1'b0}}, 1'b1} << w_pick.idx;
          w_req_out_n = 1'b1;
          w_state_n   = FWD;
        end
      end
      FWD: begin
        if (w_ack_s[0]) begin
          w_ack_in_n = r_grant;
          w_state_n  = HOLD;
        end
      end
      HOLD: begin
        if (!w_req_s[r_gidx]) begin
          w_req_out_n = 1'b0;
          w_state_n   = RTZ;
        end
      end
      RTZ: begin
        if (!w_ack_s[0]) begin
          w_ack_in_n = '0;
          w_grant_n  = '0;
          w_gidx_n   = '0;
          w_ptr_n    = (r_gidx == IW'(N-1)) ? '0 : r_gidx + 1'b1;
          w_cnt_n    = r_cnt + 1'b1;
          w_state_n  = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign bus.ack_in_o    = r_ack_in;
  assign bus.req_out_o   = r_req_out;
  assign bus.grant_o     = r_grant;
  assign bus.grant_idx_o = r_gidx;
  assign bus.busy_o      = r_busy;
  assign bus.txn_count_o = r_cnt;

endmodule

// File: doc/hs_rr_arbiter.md
Name: hs_rr_arbiter

Overview:
- Clocked round-robin arbiter that shares one downstream four-phase (return-to-zero) req/ack channel among N upstream four-phase requesters.
- Each granted requester gets one full handshake cycle. A one-hot grant and a binary index steer the shared data mux.
- Sits between several producers and a single join/C-element stage. It serialises their tokens so the stage never sees overlapping requests.

Parameters:
N, 4, number of requesters (2..16)
SYNC_STAGES, 2, synchroniser flops on every req_in_i bit and on ack_out_i (0 = inputs already synchronous to clk_i)
CNT_W, 16, width of the completed-transaction counter

Ports:
clk_i  in  1  single clock
rst_i  in  1  asynchronous, active-high reset
req_in_i  in  N  four-phase request from each requester
ack_in_o  out  N  four-phase acknowledge to each requester
req_out_o  out  1  request to the shared downstream channel
ack_out_i  in  1  acknowledge from the downstream channel
grant_o  out  N  one-hot owner of the channel, all-zero when idle
grant_idx_o  out  max(1,$clog2(N))  binary index of the owner, for the data mux
busy_o  out  1  high in any state other than IDLE
txn_count_o  out  CNT_W  number of completed handshakes, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.
- All outputs are registered. Reset values: ack_in_o=0, req_out_o=0, grant_o=0, grant_idx_o=0, busy_o=0, txn_count_o=0, rr pointer=0, state=IDLE, synchroniser flops=0.
- Inputs below mean synchronised values (r = req_in after SYNC_STAGES flops, a = ack_out after SYNC_STAGES flops).
- FSM states and transitions:
  - IDLE: if any r bit is set, pick the first set bit at or after the pointer, scanning upward and wrapping. Next cycle: grant_o/grant_idx_o set, req_out_o=1, go to FWD.
  - FWD: hold req_out_o=1. When a=1, set ack_in_o[g]=1 and go to HOLD.
  - HOLD: hold req_out_o=1 and ack_in_o[g]=1. When r[g]=0, set req_out_o=0 and go to RTZ.
  - RTZ: hold ack_in_o[g]=1. When a=0: ack_in_o[g]=0, grant cleared, pointer=(g+1) mod N, txn_count_o+1, go to IDLE.
- Event order per token: req_in↑ → req_out↑ → ack_out↑ → ack_in↑ → req_in↓ → req_out↓ → ack_out↓ → ack_in↓.
- Minimum latencies with SYNC_STAGES=0:
  - req_in↑ to req_out↑: 1 cycle.
  - ack_out↑ to ack_in↑: 1 cycle.
  - A full token takes at least 4 cycles plus downstream delay.
  - Each synchroniser stage adds 1 cycle on the affected edge.
- Grant is stable from the IDLE→FWD transition until the RTZ→IDLE transition. Requests from other requesters arriving meanwhile are ignored until IDLE.
- Requester ownership and arbitration:
  - At most one ack_in_o bit is ever high. It is always the granted bit.
  - Simultaneous requests: the lowest index at or above the pointer wins. The pointer guarantees no requester waits more than N-1 tokens.
  - A requester whose req stays high after its token completes is served again only after the pointer has passed the others that are requesting. If it is the only one requesting, it is re-granted on the first IDLE cycle.
- Protocol violations (tolerated, not flagged):
  - r[g] falling in FWD: ignored until HOLD. The FSM does not abort.
  - a falling before HOLD is left: ignored; waits for r[g]=0 first.
  - Non-granted req bits toggling: no effect.
- Reset mid-operation: all outputs drop to 0 asynchronously. Pointer returns to 0 and any in-flight token is discarded. Requesters and downstream must be reset together.
- IDLE is always one clock between tokens: back-to-back grants are separated by at least one cycle of req_out_o=0.

Decomposition:
- Shared package hs_pkg holds:
  - typedef hs_state_e (IDLE, FWD, HOLD, RTZ), 2-bit enum;
  - function rr_pick(req, ptr), returning the winning index and a valid flag.
- Sub-module sync_ff: a SYNC_STAGES-deep, width-parameterised flop chain with async active-high reset. It is instantiated once for the N req bits and once for ack_out_i, and is a wire when SYNC_STAGES=0.

Test Plan:
- Single requester, SYNC_STAGES=0, N=4: req_in_i=0001, downstream acks 2 cycles after req_out.
  - Expect req_out_o↑ at cycle 1, grant_o=0001, grant_idx_o=0, ack_in_o=0001 one cycle after ack_out↑.
  - After the full RTZ: txn_count_o=1, busy_o=0.
- Contention: req_in_i=1111 held through every handshake.
  - Grants in order 0,1,2,3,0; never two ack_in_o bits set; txn_count_o=5 after 5 tokens.
- Pointer fairness: complete a token for requester 2, then assert req_in_i=0101.
  - Requester 0 is granted (scan from 3 wraps to 0); the next grant is requester 2.
- Latency with SYNC_STAGES=2: step req_in_i[1].
  - req_out_o rises exactly 3 cycles later.
  - ack_in_o[1] rises exactly 3 cycles after ack_out_i.
- Async reset in HOLD: assert rst_i between clock edges.
  - All outputs are 0 before the next edge; after release with req_in_i=1000, grant_idx_o=3 is chosen from pointer 0.
- Counter wrap with CNT_W=2: run 5 tokens -> txn_count_o reads 1,2,3,0,1.
